// File: rtl/port_bcd_display.sv
// port_bcd_display: registered six-digit seven-segment driver for a 32-bit CPU
// output port. A new word is captured whenever it differs from the last one.
// It is then converted to BCD serially, one bit per clock, and the segment
// registers are loaded once the conversion finishes. Words above 999999
// display as six dashes and raise overflow.
// Optional feature macro: PORT_DISPLAY_ZERO_BLANK_EN blanks leading zero digits.
module port_bcd_display #(
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        overflow,
  output logic        update
);

`ifdef PORT_DISPLAY_ZERO_BLANK_EN
  localparam bit ZERO_BLANK = 1'b1;
`else
  localparam bit ZERO_BLANK = 1'b0;
`endif

  localparam logic [6:0] DASH_AL  = 7'b0111111;
  localparam logic [6:0] BLANK_AL = 7'b1111111;
  localparam logic [6:0] BLANK_PAT = (SEG_ACTIVE_LOW != 0) ? BLANK_AL : ~BLANK_AL;

  typedef enum logic [0:0] {IDLE, CONV} state_t;

  state_t           state_q;
  logic [31:0]      last_q;
  logic             start_q;
  logic             ovf_pend_q;
  logic [4:0]       cnt_q;
  logic [19:0]      opnd_q;
  // Only 23 bits are kept between steps. Any prefix of an operand no greater
  // than 999999 stays below 500000, so the top BCD bit is always zero until
  // the final shift, which is taken straight from bcd_d.
  logic [22:0]      bcd_q;
  logic [5:0][6:0]  hex_q;

  logic [22:0]      bcd_adj;
  logic [23:0]      bcd_d;
  logic [5:0]       lead_zero_d;
  logic [5:0][6:0]  seg_d;
  logic             capture_d;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    case (d)
      4'd0:    enc_digit = 7'b1000000;
      4'd1:    enc_digit = 7'b1111001;
      4'd2:    enc_digit = 7'b0100100;
      4'd3:    enc_digit = 7'b0110000;
      4'd4:    enc_digit = 7'b0011001;
      4'd5:    enc_digit = 7'b0010010;
      4'd6:    enc_digit = 7'b0000010;
      4'd7:    enc_digit = 7'b1111000;
      4'd8:    enc_digit = 7'b0000000;
      4'd9:    enc_digit = 7'b0010000;
      default: enc_digit = BLANK_AL;
    endcase
  endfunction

  // Add-3 correction on the five low nibbles. The top nibble is never 5 or
  // more before a shift, so it passes through unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                            : bcd_q[gi*4 +: 4];
    end
  endgenerate
  assign bcd_adj[22:20] = bcd_q[22:20];
  assign bcd_d = {bcd_adj, opnd_q[19]};

  // Segment patterns for the finished conversion, with dash, blanking and
  // polarity applied.
  generate
    for (gi = 0; gi < 6; gi++) begin : g_seg
      logic [6:0] pat_al;
      if (gi == 0) begin : g_lsd
        assign lead_zero_d[gi] = 1'b0;
      end else begin : g_upper
        assign lead_zero_d[gi] = (bcd_d[23:gi*4] == '0);
      end
      assign pat_al = ovf_pend_q                     ? DASH_AL  :
                      (ZERO_BLANK && lead_zero_d[gi]) ? BLANK_AL :
                      enc_digit(bcd_d[gi*4 +: 4]);
      assign seg_d[gi] = (SEG_ACTIVE_LOW != 0) ? pat_al : ~pat_al;
    end
  endgenerate

  assign capture_d = (value != last_q) || start_q;

  // Capture/convert FSM; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      start_q    <= 1'b1;
      ovf_pend_q <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      bcd_q      <= '0;
      hex_q      <= {6{BLANK_PAT}};
      busy       <= 1'b0;
      overflow   <= 1'b0;
      update     <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture_d) begin
            last_q     <= value;
            start_q    <= 1'b0;
            ovf_pend_q <= (value > 32'd999999);
            opnd_q     <= (value > 32'd999999) ? 20'd0 : value[19:0];
            bcd_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          bcd_q  <= bcd_d[22:0];
          opnd_q <= {opnd_q[18:0], 1'b0};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd19) begin
            hex_q    <= seg_d;
            overflow <= ovf_pend_q;
            update   <= 1'b1;
            busy     <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_port_bcd_display.sv
// Scoreboard bench for port_bcd_display: a behavioural model predicts which
// words are captured and when, and pushes the expected display; a monitor
// pops entries on each update pulse and checks the outputs every cycle.
module tb_port_bcd_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = 32'd0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy, overflow, update;

  always #5 clock = ~clock;

  port_bcd_display dut (
    .clock(clock), .reset(reset), .value(value),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .overflow(overflow), .update(update)
  );

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_left = 0;
  bit          done = 1'b0;
  localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};

  // Expected display for a word, computed from decimal arithmetic.
  function automatic logic [41:0] exp_hex(input logic [31:0] v);
    logic [6:0] seg_tab [10];
    logic [41:0] r;
    longint unsigned p;
    int d;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    r = '0;
    p = 1;
    for (int k = 0; k < 6; k++) begin
      d = int'((longint'(v) / p) % 10);
      if (v > 32'd999999) r[k*7 +: 7] = 7'b0111111;
      else r[k*7 +: 7] = seg_tab[d];
`ifdef PORT_DISPLAY_ZERO_BLANK_EN
      if (v <= 32'd999999 && k > 0 && longint'(v) < p) r[k*7 +: 7] = 7'b1111111;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Reference model: a word is taken when idle and either new or first after
  // reset; its display is due 20 edges later, and reset discards it.
  bit          m_start = 1'b1;
  logic [31:0] m_last = '0;
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_start   = 1'b1;
        busy_left = 0;
        sb.delete();
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (m_start || value != m_last) begin
        exp_t e;
        m_start   = 1'b0;
        m_last    = value;
        e.hex     = exp_hex(value);
        e.ovf     = (value > 32'd999999);
        e.due     = cyc + 20;
        e.val     = value;
        sb.push_back(e);
        busy_left = 20;
      end
    end
  end

  // Monitor: samples on the falling edge, pops on every update pulse.
  logic [41:0] shown = ALL_BLANK;
  logic        shown_ovf = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));
        chk("reset_update", 64'(update), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        shown     = ALL_BLANK;
        shown_ovf = 1'b0;
      end else begin
        chk("busy", 64'(busy), 64'(busy_left != 0));
        if (update) begin
          if (sb.size() == 0) begin
            chk("unexpected_update", 64'(update), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("update_latency", 64'(cyc), 64'(e.due));
            shown     = e.hex;
            shown_ovf = e.ovf;
            $display("update value=%0d hex=%h ovf=%0d cycle=%0d", e.val,
                     {hex5, hex4, hex3, hex2, hex1, hex0}, overflow, cyc);
          end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
          chk("missing_update", 64'(update), 64'd1);
          void'(sb.pop_front());
        end
        chk("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(shown));
        chk("overflow", 64'(overflow), 64'(shown_ovf));
      end
      if (done) begin
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic drive(input logic [31:0] v, input int n);
    @(negedge clock);
    #1;
    value = v;
    repeat (n) @(negedge clock);
  endtask

  // Stimulus: directed scenarios, then randomized words and hold times.
  initial begin
    repeat (3) @(negedge clock);
    #1;
    value = 32'd123456;
    reset = 1'b0;
    repeat (30) @(negedge clock);
    drive(32'd0, 25);
    drive(32'd1000000, 25);
    drive(32'hFFFFFFFF, 25);
    drive(32'd42, 5);
    drive(32'd999999, 50);
    drive(32'd777, 10);
    #1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (30) @(negedge clock);
    repeat (100) @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0:       v = 32'($urandom_range(0, 999));
        1:       v = 32'($urandom_range(0, 999999));
        2:       v = $urandom;
        default: v = value;
      endcase
      drive(v, $urandom_range(1, 30));
    end
    repeat (25) @(negedge clock);
    done = 1'b1;
  end

endmodule
